// File: rtl/m6502_bus_pkg.sv
// Shared definitions for the 6502-style peripheral bus master.
package m6502_bus_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;

  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_RX_AVAIL = 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BOUNDARY,
    POLL,
    ACCESS,
    RESP
  } bus_state_t;

  // One full phi2 cycle worth of bus pin values.
  typedef struct packed {
    logic       ncs;
    logic       nwe;
    logic [1:0] addr;
    logic [7:0] data;
    logic       oe;
  } bus_cycle_t;

  localparam bus_cycle_t IDLE_CYCLE = '{ncs: 1'b1, nwe: 1'b1, addr: 2'd0, data: 8'd0, oe: 1'b0};

  // A write waits for the transmitter to go idle; a read waits for received data.
  function automatic logic status_ready(input logic is_write, input logic [7:0] status);
    return is_write ? ~status[STAT_TX_BUSY] : status[STAT_RX_AVAIL];
  endfunction

endpackage

// File: rtl/m6502_bus_master_if.sv
// Request/response handshake plus peripheral bus pins of the bus master.
interface m6502_bus_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_wait;

  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;

  logic       phi2;
  logic       ncs;
  logic       nwe;
  logic [1:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wait, data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output phi2, ncs, nwe, addr, data_out, data_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wait, data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  phi2, ncs, nwe, addr, data_out, data_oe
  );

endinterface

// File: rtl/m6502_phi2_gen.sv
// Free-running phi2 generator: PHI2_HALF clk low, then PHI2_HALF clk high.
module m6502_phi2_gen #(
  parameter int PHI2_HALF = 8
) (
  input  logic clk,
  input  logic reset,
  output logic phi2,
  output logic fall_strobe,
  output logic sample_strobe
);

  localparam int PERIOD = 2 * PHI2_HALF;
  localparam int CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] SAMPLE = CW'(PERIOD - 2);
  localparam logic [CW-1:0] HALF   = CW'(PHI2_HALF);

  logic [CW-1:0] phase;
  logic [CW-1:0] phase_n;

  // phase wraps at the end of the high half
  always_comb begin
    phase_n = (phase == LAST) ? '0 : phase + CW'(1);
  end

  // phi2 is registered from the next phase so it has no decode glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      phi2  <= 1'b0;
    end else begin
      phase <= phase_n;
      phi2  <= (phase_n >= HALF);
    end
  end

  // fall_strobe marks the clk whose ending edge drops phi2; sample_strobe
  // loads data_in on the edge that starts the last high clk, a clk ahead of
  // the boundary so the value is ready when the cycle ends.
  assign fall_strobe   = (phase == LAST);
  assign sample_strobe = (phase == SAMPLE);

endmodule

// File: rtl/m6502_bus_master.sv
// Bus initiator: runs single register reads/writes on the 6502-style bus,
// optionally polling the status register first.
//
// state         | meaning
// IDLE          | req_ready high, waiting for a request
// WAIT_BOUNDARY | request captured, waiting for the next phi2 fall
// POLL          | status read cycle at addr 0
// ACCESS        | the requested read or write cycle
// RESP          | one-clk rsp_valid pulse
module m6502_bus_master
  import m6502_bus_pkg::*;
#(
  parameter int PHI2_HALF  = 8,
  parameter int POLL_LIMIT = 255
) (
  input logic                 clk,
  input logic                 reset,
  m6502_bus_master_if.master  bus
);

  bus_state_t state, state_n;
  bus_cycle_t cyc_q, cyc_n;

  logic       phi2, fall_strobe, sample_strobe;
  logic       accept, poll_ok, poll_expired;
  logic       cap_write, cap_wait;
  logic [1:0] cap_addr;
  logic [7:0] cap_wdata;
  logic [7:0] poll_cnt;
  logic [7:0] rd_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_timeout_q;

  m6502_phi2_gen #(.PHI2_HALF(PHI2_HALF)) u_phi2 (
    .clk           (clk),
    .reset         (reset),
    .phi2          (phi2),
    .fall_strobe   (fall_strobe),
    .sample_strobe (sample_strobe)
  );

  assign accept       = bus.req_valid && bus.req_ready;
  assign poll_ok      = status_ready(cap_write, rd_q);
  assign poll_expired = (poll_cnt == 8'(POLL_LIMIT));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state; every bus-phase transition waits for a phi2 fall
  always_comb begin
    state_n = state;
    case (state)
      IDLE:          if (accept) state_n = WAIT_BOUNDARY;
      WAIT_BOUNDARY: if (fall_strobe) state_n = cap_wait ? POLL : ACCESS;
      POLL: begin
        if (fall_strobe) begin
          if (poll_ok)           state_n = ACCESS;
          else if (poll_expired) state_n = RESP;
          else                   state_n = POLL;
        end
      end
      ACCESS:        if (fall_strobe) state_n = RESP;
      RESP:          state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end

  // pin values for the bus cycle that the coming boundary starts
  always_comb begin
    cyc_n = IDLE_CYCLE;
    if (state_n == POLL) begin
      cyc_n.ncs  = 1'b0;
      cyc_n.addr = REG_STATUS;
    end else if (state_n == ACCESS) begin
      cyc_n.ncs  = 1'b0;
      cyc_n.nwe  = ~cap_write;
      cyc_n.addr = cap_addr;
      cyc_n.data = cap_write ? cap_wdata : 8'd0;
      cyc_n.oe   = cap_write;
    end
  end

  // bus pins load only on the boundary so they hold for a whole phi2 cycle
  always_ff @(posedge clk) begin
    if (reset)            cyc_q <= IDLE_CYCLE;
    else if (fall_strobe) cyc_q <= cyc_n;
  end

  // request capture and poll counting
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_write <= 1'b0;
      cap_wait  <= 1'b0;
      cap_addr  <= 2'd0;
      cap_wdata <= 8'd0;
      poll_cnt  <= 8'd0;
    end else if (accept) begin
      cap_write <= bus.req_write;
      cap_wait  <= bus.req_wait;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      poll_cnt  <= 8'd0;
    end else if (fall_strobe && state_n == POLL) begin
      poll_cnt  <= poll_cnt + 8'd1;
    end
  end

  // read data capture late in the high half
  always_ff @(posedge clk) begin
    if (reset)              rd_q <= 8'd0;
    else if (sample_strobe) rd_q <= bus.data_in;
  end

  // response fields load on entry to RESP and hold until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata_q   <= 8'd0;
      rsp_timeout_q <= 1'b0;
    end else if (state != RESP && state_n == RESP) begin
      rsp_timeout_q <= (state == POLL);
      rsp_rdata_q   <= (state == POLL || cap_write) ? 8'd0 : rd_q;
    end
  end

  assign bus.req_ready   = (state == IDLE) && !reset;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.phi2        = phi2;
  assign bus.ncs         = cyc_q.ncs;
  assign bus.nwe         = cyc_q.nwe;
  assign bus.addr        = cyc_q.addr;
  assign bus.data_out    = cyc_q.data;
  assign bus.data_oe     = cyc_q.oe;

endmodule

// File: tb/tb_m6502_bus_master.sv
// Bench for m6502_bus_master: a transaction-level timeline model predicts
// every pin on every clk; a small peripheral model answers bus reads.
module tb_m6502_bus_master;
  import m6502_bus_pkg::*;

  localparam int H     = 8;
  localparam int P     = 2 * H;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  m6502_bus_master_if bus();

  m6502_bus_master #(.PHI2_HALF(H), .POLL_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  logic [7:0] status_arr [0:7];
  int         status_len;
  logic [7:0] periph_data;
  int         poll_idx;
  logic [7:0] stat_val;

  function automatic logic [7:0] stat_at(input int i);
    logic [2:0] si;
    si = (i < status_len) ? 3'(i) : 3'(status_len - 1);
    return status_arr[si];
  endfunction

  always_comb begin
    stat_val    = stat_at(poll_idx);
    bus.data_in = 8'hEE;
    if (bus.phi2 && !bus.ncs && bus.nwe)
      bus.data_in = (bus.addr == REG_STATUS) ? stat_val : periph_data;
  end

  // ---------------- timeline model ----------------
  // t counts clk edges since reset; phi2 falls on every edge with t % P == 0.
  int         t = 0;
  bit         m_active = 1'b0;
  int         m_b, m_end, m_polls;
  bit         m_wr;
  logic [1:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] m_hold = 8'd0;
  bit         m_to;
  int         acc_cnt = 0;

  int   exp_polls, exp_b, exp_n, exp_end;
  bit   exp_to;
  bit   m_ready;

  always_comb begin
    exp_to    = 1'b1;
    exp_polls = LIMIT;
    for (int i = LIMIT - 1; i >= 0; i--) begin
      if (bus.req_write ? !stat_at(i)[0] : stat_at(i)[1]) begin
        exp_polls = i + 1;
        exp_to    = 1'b0;
      end
    end
    if (!bus.req_wait) begin
      exp_polls = 0;
      exp_to    = 1'b0;
    end
    exp_b   = ((t + 1) / P + 1) * P;
    exp_n   = exp_polls + (exp_to ? 0 : 1);
    exp_end = exp_b + exp_n * P;
    m_ready = !(m_active && t <= m_end);
  end

  always @(posedge clk) begin
    if (reset) begin
      t        <= 0;
      m_active <= 1'b0;
      m_hold   <= 8'd0;
      poll_idx <= 0;
    end else begin
      t <= t + 1;
      if (bus.req_valid && m_ready) begin
        m_active <= 1'b1;
        m_b      <= exp_b;
        m_end    <= exp_end;
        m_polls  <= exp_polls;
        m_to     <= exp_to;
        m_wr     <= bus.req_write;
        m_addr   <= bus.req_addr;
        m_wdata  <= bus.req_wdata;
        m_rdata  <= (exp_to || bus.req_write) ? 8'd0 : periph_data;
        acc_cnt  <= acc_cnt + 1;
        poll_idx <= 0;
      end else if (!bus.ncs && bus.nwe && bus.addr == REG_STATUS && (t % P) == P - 1) begin
        poll_idx <= poll_idx + 1;
      end
      if (m_active && t + 1 == m_end) m_hold <= m_rdata;
    end
  end

  // expected pins for the current clk
  bit         e_ncs, e_nwe, e_oe, e_phi2, e_ready, e_rsp, in_txn;
  logic [1:0] e_addr;
  logic [7:0] e_data;
  int         k;

  always_comb begin
    in_txn = m_active && t >= m_b && t < m_end;
    k      = in_txn ? (t - m_b) / P : 0;
    e_ncs  = !in_txn;
    e_nwe  = 1'b1;
    e_oe   = 1'b0;
    e_addr = REG_STATUS;
    e_data = 8'd0;
    if (in_txn && k >= m_polls) begin
      e_nwe  = !m_wr;
      e_oe   = m_wr;
      e_addr = m_addr;
      e_data = m_wdata;
    end
    e_phi2  = (t % P) >= H;
    e_ready = !reset && m_ready;
    e_rsp   = m_active && t == m_end;
  end

  // ---------------- compare and observation ----------------
  int         obs_low = 0, obs_stat = 0, obs_acc = 0, obs_rsp = 0;
  logic [7:0] last_rdata = 8'd0;
  logic       last_to = 1'b0;
  int         obs_cyc[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("phi2",      32'(bus.phi2),      32'(e_phi2));
      check("req_ready", 32'(bus.req_ready), 32'(e_ready));
      check("ncs",       32'(bus.ncs),       32'(e_ncs));
      check("nwe",       32'(bus.nwe),       32'(e_nwe));
      check("data_oe",   32'(bus.data_oe),   32'(e_oe));
      if (!e_ncs) check("addr", 32'(bus.addr), 32'(e_addr));
      if (e_oe)   check("data_out", 32'(bus.data_out), 32'(e_data));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_hold));
      if (e_rsp) check("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_to));

      if (!bus.ncs) obs_low <= obs_low + 1;
      if (!bus.ncs && (t % P) == P - 1) begin
        if (bus.addr == REG_STATUS) obs_stat <= obs_stat + 1;
        else                        obs_acc  <= obs_acc + 1;
        obs_cyc.push_back(t / P);
      end
      if (bus.rsp_valid) begin
        obs_rsp    <= obs_rsp + 1;
        last_rdata <= bus.rsp_rdata;
        last_to    <= bus.rsp_timeout;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [1:0] a, input logic [7:0] d, input bit wt);
    int start, guard;
    start         = acc_cnt;
    guard         = 0;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wait  = wt;
    bus.req_valid = 1'b1;
    while (acc_cnt == start && guard < 400) begin
      step();
      guard++;
    end
    bus.req_valid = 1'b0;
    check("accept_bound", 32'(guard < 400), 32'd1);
  endtask

  task automatic finish_txn();
    int guard;
    guard = 0;
    while (m_active && t <= m_end && guard < 2000) begin
      step();
      guard++;
    end
    check("done_bound", 32'(guard < 2000), 32'd1);
    step();
    step();
  endtask

  int s_low, s_stat, s_acc, s_rsp, guard;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_wdata = 8'd0;
    bus.req_wait  = 1'b0;
    periph_data   = 8'h00;
    status_len    = 1;
    for (int i = 0; i < 8; i++) status_arr[i] = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (5) step();

    // 1: plain write
    s_low = obs_low; s_acc = obs_acc;
    issue(1'b1, REG_DATA, 8'hA5, 1'b0);
    finish_txn();
    check("t1_ncs_low_clks", 32'(obs_low - s_low), 32'd16);
    check("t1_access_cycles", 32'(obs_acc - s_acc), 32'd1);
    check("t1_rdata", 32'(last_rdata), 32'h00);
    check("t1_timeout", 32'(last_to), 32'd0);

    // 2: plain read
    periph_data = 8'h5A;
    s_low = obs_low;
    issue(1'b0, REG_DATA, 8'h00, 1'b0);
    finish_txn();
    check("t2_ncs_low_clks", 32'(obs_low - s_low), 32'd16);
    check("t2_rdata", 32'(last_rdata), 32'h5A);

    // 3: write after polling tx_busy three times
    status_arr[0] = 8'h01; status_arr[1] = 8'h01; status_arr[2] = 8'h01; status_arr[3] = 8'h00;
    status_len = 4;
    s_low = obs_low; s_stat = obs_stat; s_acc = obs_acc;
    issue(1'b1, REG_DATA, 8'h41, 1'b1);
    finish_txn();
    check("t3_status_reads", 32'(obs_stat - s_stat), 32'd4);
    check("t3_access_cycles", 32'(obs_acc - s_acc), 32'd1);
    check("t3_ncs_low_clks", 32'(obs_low - s_low), 32'd80);
    check("t3_timeout", 32'(last_to), 32'd0);

    // 4: read with rx_available never set
    status_arr[0] = 8'h00;
    status_len = 1;
    s_stat = obs_stat; s_acc = obs_acc;
    issue(1'b0, REG_DATA, 8'h00, 1'b1);
    finish_txn();
    check("t4_status_reads", 32'(obs_stat - s_stat), 32'd4);
    check("t4_access_cycles", 32'(obs_acc - s_acc), 32'd0);
    check("t4_timeout", 32'(last_to), 32'd1);
    check("t4_rdata", 32'(last_rdata), 32'h00);

    // 6: req_valid held across two back-to-back requests
    s_rsp = obs_rsp; s_acc = obs_acc;
    bus.req_write = 1'b1;
    bus.req_addr  = REG_DATA;
    bus.req_wdata = 8'h77;
    bus.req_wait  = 1'b0;
    bus.req_valid = 1'b1;
    guard = 0;
    while (acc_cnt < s_acc + 0 + (acc_cnt - acc_cnt) + 0 && guard < 0) guard++;
    guard = 0;
    s_stat = acc_cnt;
    while (acc_cnt < s_stat + 2 && guard < 400) begin
      step();
      guard++;
    end
    bus.req_valid = 1'b0;
    check("t6_accept_bound", 32'(guard < 400), 32'd1);
    finish_txn();
    check("t6_responses", 32'(obs_rsp - s_rsp), 32'd2);
    check("t6_access_cycles", 32'(obs_acc - s_acc), 32'd2);
    if (obs_cyc.size() >= 2)
      check("t6_idle_gap", 32'((obs_cyc[obs_cyc.size()-1] - obs_cyc[obs_cyc.size()-2]) >= 2), 32'd1);
    else
      check("t6_cycle_log", 32'(obs_cyc.size()), 32'd2);

    // 5: reset during the high half of a write
    s_rsp = obs_rsp;
    issue(1'b1, REG_DATA, 8'h33, 1'b0);
    guard = 0;
    while (t < m_b + H + 2 && guard < 400) begin
      step();
      guard++;
    end
    check("t5_reach_bound", 32'(guard < 400), 32'd1);
    check("t5_mid_ncs", 32'(bus.ncs), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_ncs_after_reset", 32'(bus.ncs), 32'd1);
    check("t5_oe_after_reset", 32'(bus.data_oe), 32'd0);
    check("t5_phi2_after_reset", 32'(bus.phi2), 32'd0);
    check("t5_ready_after_reset", 32'(bus.req_ready), 32'd1);
    repeat (3 * P) step();
    check("t5_no_response", 32'(obs_rsp - s_rsp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
